hdmi_text_vram_axi: RTL



---
 rtl/hdmi_text_vram_axi_if.sv | 32 +++
 rtl/hdmi_text_vram_axi.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_text_vram_axi_if.sv
// AXI4-Lite bus bundle between the text-mode VRAM slave and its CPU-side master.
interface hdmi_text_vram_axi_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/hdmi_text_vram_axi.sv
// AXI4-Lite text-mode VRAM (80x30 glyph words + colour word at index 600), read whole by the colour mapper.
// Optional VRAM_VSYNC_SHADOW_EN: colour writes go to a shadow that is published on vsync falling edge.
module hdmi_text_vram_axi #(
    parameter int unsigned VRAM_WORDS = 601,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vsync,
    hdmi_text_vram_axi_if.slave s_axi,
    output logic [31:0]         vram [VRAM_WORDS]
);
    localparam int unsigned IDX_W       = ADDR_W - 2;
    localparam int unsigned MEM_IW      = $clog2(VRAM_WORDS);
    localparam int unsigned COLOR_IDX   = 600;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_VALID} r_state_t;

    w_state_t         r_wstate, w_wstate_nxt;
    r_state_t         r_rstate, w_rstate_nxt;
    logic [31:0]      r_mem [VRAM_WORDS];
    logic [IDX_W-1:0] r_awidx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]       r_bresp, r_rresp;
    logic [31:0]      r_rdata;

    logic             w_aw_hs, w_w_hs, w_ar_hs;
    logic             w_commit, w_cidx_ok, w_to_shadow;
    logic [IDX_W-1:0] w_cidx, w_aridx;
    logic [31:0]      w_cdata, w_color_rd;
    logic [3:0]       w_cstrb;
    logic             w_aridx_ok;
    logic             w_unused_addr_lsbs;

    assign w_aw_hs            = s_axi.awvalid & r_awready;
    assign w_w_hs             = s_axi.wvalid & r_wready;
    assign w_ar_hs            = s_axi.arvalid & r_arready;
    assign w_aridx            = s_axi.araddr[ADDR_W-1:2];
    assign w_aridx_ok         = 32'(w_aridx) < VRAM_WORDS;
    assign w_cidx_ok          = 32'(w_cidx) < VRAM_WORDS;
    assign w_unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Write FSM: AW and W may arrive in either order; commit selects latched or live halves
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        w_cidx       = s_axi.awaddr[ADDR_W-1:2];
        w_cdata      = s_axi.wdata;
        w_cstrb      = s_axi.wstrb;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_ADDR;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                w_cidx = r_awidx;
                if (w_w_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                w_cdata = r_wdata;
                w_cstrb = r_wstrb;
                if (w_aw_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_DATA);
            r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_ADDR);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_commit) r_bresp <= w_cidx_ok ? RESP_OKAY : RESP_SLVERR;
            if ((r_wstate == W_IDLE) && w_aw_hs) r_awidx <= s_axi.awaddr[ADDR_W-1:2];
            if ((r_wstate == W_IDLE) && w_w_hs) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end
        end
    end

`ifdef VRAM_VSYNC_SHADOW_EN
    logic [31:0] r_shadow;
    logic        r_vs_q1, r_vs_q2;
    logic        w_vs_fall;

    assign w_vs_fall   = r_vs_q2 & ~r_vs_q1;
    assign w_to_shadow = (32'(w_cidx) == COLOR_IDX);
    assign w_color_rd  = r_shadow;

    // Colour shadow and vsync falling-edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_vs_q1  <= 1'b1;
            r_vs_q2  <= 1'b1;
        end else begin
            r_vs_q1 <= vsync;
            r_vs_q2 <= r_vs_q1;
            if (w_commit && w_to_shadow) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_cstrb[b]) r_shadow[8*b +: 8] <= w_cdata[8*b +: 8];
                end
            end
        end
    end
`else
    logic w_unused_vsync;

    assign w_unused_vsync = vsync;
    assign w_to_shadow    = 1'b0;
    assign w_color_rd     = r_mem[MEM_IW'(COLOR_IDX)];
`endif

    // Storage: byte-lane writes; out-of-range commits are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < VRAM_WORDS; k++) r_mem[MEM_IW'(k)] <= '0;
        end else begin
            if (w_commit && w_cidx_ok && !w_to_shadow) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_cstrb[b]) r_mem[MEM_IW'(w_cidx)][8*b +: 8] <= w_cdata[8*b +: 8];
                end
            end
`ifdef VRAM_VSYNC_SHADOW_EN
            if (w_vs_fall) r_mem[MEM_IW'(COLOR_IDX)] <= r_shadow;
`endif
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_VALID;
            R_VALID: if (s_axi.rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read data is captured at AR handshake so it stays stable through an rready stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_VALID);
            if (w_ar_hs) begin
                if (!w_aridx_ok) begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end else begin
                    r_rdata <= (32'(w_aridx) == COLOR_IDX) ? w_color_rd : r_mem[MEM_IW'(w_aridx)];
                    r_rresp <= RESP_OKAY;
                end
            end
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign vram          = r_mem;
endmodule
